// File: rtl/system_pkg.sv
// Shared system constants: memory-map addresses of the UART registers and the
// receive FIFO depth used by the decoder and the UART receive buffer.
package system_pkg;

  localparam logic [15:0] ADDR_UART_DATA      = 16'h0400;
  localparam logic [15:0] ADDR_UART_RX_STATUS = 16'h0401;
  localparam logic [15:0] ADDR_UART_TX_STATUS = 16'h0402;
  localparam int          UART_FIFO_DEPTH     = 16;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO between uart_rx and the memory-map decoder.
// Each rising edge of the uart_rx ready level enqueues one byte; the core
// drains bytes with I_pop (read of the data register). The head byte is
// presented first-word fall-through and reads as 0 while the FIFO is empty.
// A push into a full FIFO with no simultaneous pop is dropped and latches the
// sticky overflow flag until I_clear_ovf.
module uart_rx_fifo
  import system_pkg::*;
#(
  parameter int DEPTH = UART_FIFO_DEPTH,  // power of two, at least 2
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          I_clk,
  input  logic          I_reset,
  input  logic          I_rx_ready,
  input  logic [7:0]    I_rx_data,
  input  logic          I_pop,
  input  logic          I_clear_ovf,
  output logic [7:0]    O_data,
  output logic          O_data_ready,
  output logic          O_full,
  output logic [AW:0]   O_count,
  output logic          O_overflow
);

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          rx_q;

  logic empty, full, push, pop_ok, push_ok, drop;

  // Occupancy flags come from the registered count only: with AW-bit pointers
  // equal pointers mean either empty or full, so the count breaks the tie.
  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);

  // One push per uart_rx byte, however long its ready level stays high.
  assign push    = I_rx_ready & ~rx_q;
  assign pop_ok  = I_pop & ~empty;
  // When full, a same-cycle pop frees the slot the push is written into.
  assign push_ok = push & (~full | pop_ok);
  assign drop    = push & full & ~pop_ok;

  // Next-state for pointers, occupancy and the sticky overflow flag.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (push_ok && !pop_ok)      count_d = count_q + CNT_ONE;
    else if (!push_ok && pop_ok) count_d = count_q - CNT_ONE;
    // A drop in the same cycle as a clear leaves the flag set.
    if (drop)             ovf_d = 1'b1;
    else if (I_clear_ovf) ovf_d = 1'b0;
  end

  // Control state with asynchronous active-low reset; queued bytes are discarded.
  always_ff @(posedge I_clk or negedge I_reset) begin
    if (!I_reset) begin
      rx_q     <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      rx_q     <= I_rx_ready;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Byte storage, left unreset so it can map onto distributed RAM.
  always_ff @(posedge I_clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= I_rx_data;
  end

  assign O_data       = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign O_data_ready = ~empty;
  assign O_full       = full;
  assign O_count      = count_q;
  assign O_overflow   = ovf_q;

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive buffer between uart_rx and the system memory-map decoder.
- Captures each byte uart_rx delivers and queues it in a FIFO. The core then drains bytes at its own pace through the 0x400 (data) and 0x401 (status) reads.
- Prevents byte loss while the core is busy with RAM traffic.

Parameters:
- DEPTH, 16, number of byte entries; must be a power of two, minimum 2.
- AW, 4, pointer width; equals log2(DEPTH).

Ports:
- I_clk  input  1  system clock.
- I_reset  input  1  asynchronous reset, active-low.
- I_rx_ready  input  1  uart_rx O_data_ready (level; high while a received byte is valid).
- I_rx_data  input  8  uart_rx O_data.
- I_pop  input  1  one-cycle read strobe from the decoder (core read of 0x400).
- I_clear_ovf  input  1  one-cycle strobe; clears O_overflow.
- O_data  output  8  byte at the FIFO head (first-word fall-through); 0 when empty.
- O_data_ready  output  1  FIFO not empty.
- O_full  output  1  FIFO holds DEPTH entries.
- O_count  output  AW+1  current occupancy, 0..DEPTH.
- O_overflow  output  1  sticky flag; a byte was dropped because the FIFO was full.

Behaviour:
- Reset (I_reset low, any time, asynchronous):
  - Pointers and count go to 0; storage contents are don't-care.
  - O_data=0, O_data_ready=0, O_full=0, O_count=0, O_overflow=0.
  - Edge-detect register is cleared to 0.
  - Reset mid-operation discards all queued bytes. If I_rx_ready is still high at release, that byte is captured on the first edge after release.
- Push detection:
  - rx_q registers I_rx_ready each cycle.
  - push = I_rx_ready & ~rx_q, so each uart_rx byte is captured exactly once regardless of level duration.
  - I_rx_data is sampled in the push cycle.
- Push (push=1, not full):
  - mem[wr_ptr] <= I_rx_data; wr_ptr increments modulo DEPTH; count increments.
- Pop (I_pop=1, not empty): rd_ptr increments modulo DEPTH; count decrements.
- Pop when empty: ignored; no pointer or count change, no error flag.
- Push when full, with no pop in the same cycle: byte dropped, O_overflow <= 1, pointers unchanged.
- Push and pop in the same cycle:
  - Not empty and not full: both pointers advance, count unchanged.
  - Full: pop frees a slot, push is accepted, count stays DEPTH, no overflow.
  - Empty: the pop is ignored and the push is accepted; count becomes 1.
- Latency:
  - A byte pushed on edge N appears on O_data, with O_data_ready=1, after edge N. It is readable in cycle N+1.
  - O_data is combinational from mem[rd_ptr], gated to 0 when empty.
- Flags:
  - O_data_ready = (count != 0); O_full = (count == DEPTH).
  - Both are derived from the registered count, never from pointer comparison alone.
- Overflow flag:
  - Set by a dropped push; cleared by I_clear_ovf.
  - If a drop and I_clear_ovf occur in the same cycle, set wins.
- Wrap-around: pointers are AW bits and roll from DEPTH-1 to 0 silently; count alone distinguishes full from empty.
- Storage: no reset on the memory array, so it can infer distributed RAM.

Decomposition:
- Shared package system_pkg holds the memory-map constants:
  - ADDR_UART_DATA=16'h400
  - ADDR_UART_RX_STATUS=16'h401
  - ADDR_UART_TX_STATUS=16'h402
  - UART_FIFO_DEPTH=16
- No sub-module. The edge detector is a single flop kept inline.
- The decoder drives I_pop on a core read of ADDR_UART_DATA, and returns O_data_ready for a read of ADDR_UART_RX_STATUS.

Test Plan:
- Reset behaviour: hold I_reset low with I_rx_ready=1 -> all outputs 0. Release with I_rx_ready still 1 -> one push; O_count=1, O_data equals I_rx_data.
- Single byte round trip: pulse I_rx_ready high for 5 cycles with data 8'hA5 -> exactly one entry; O_data=8'hA5 the cycle after the rising edge. Pulse I_pop -> O_data_ready=0, O_data=0.
- Fill and overflow: push 8'h00..8'h0F (16 bytes) -> O_full=1, O_count=16. Push 8'hFF -> dropped, O_overflow=1. Pop all -> order 00..0F, no FF. Pulse I_clear_ovf -> O_overflow=0.
- Simultaneous operations:
  - At count=16, push 8'h55 and pop in the same cycle -> O_count stays 16, no overflow, 8'h55 is the last byte out.
  - At count=0, push and pop in the same cycle -> O_count=1.
- Wrap and empty pop: perform 40 interleaved push/pop pairs -> FIFO order preserved across pointer wrap. Pop while empty -> O_count stays 0, no flag change.
- Asynchronous reset mid-stream: with 7 entries queued, assert I_reset low between clock edges -> outputs clear immediately without a clock. After release, new bytes start at a clean head.
